spi_rom_loader: RTL



---
 rtl/spi_rom_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_rom_loader.sv
// spi_rom_loader: boot-time loader that streams a ROM image out of an SPI
// serial flash (mode 0, READ 0x03) into the write port of the system ROM.
// Every byte becomes a single-cycle write, and done stays high once the
// image is complete.
module spi_rom_loader #(
    parameter int          KB   = 16,
    parameter int          DIV  = 2,
    parameter logic [23:0] ADDR = 24'h000000
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        cs,
    output logic                        ck,
    output logic                        mosi,
    input  logic                        miso,
    output logic [$clog2(KB*1024)-1:0]  a,
    output logic [7:0]                  d,
    output logic                        w,
    output logic                        done
);

    localparam int          N       = KB * 1024;
    localparam int          AW      = $clog2(N);
    localparam int          BW      = AW + 1;
    localparam int          CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [31:0] CMDWORD = {8'h03, ADDR};

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   divcnt;
    logic [4:0]      bitcnt;
    logic [31:0]     cmdsr;
    logic [7:0]      rxsr;
    logic [BW-1:0]   bytecnt;

    logic            tick;
    logic            rise;
    logic            fall;
    logic            cmd_end;
    logic            byte_end;
    logic            last_byte;

    // State register; reset always restarts the sequence from IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Half-period ticks, SPI edge strobes, and next-state decode.
    always_comb begin
        tick       = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        cmd_end    = 1'b0;
        byte_end   = 1'b0;
        last_byte  = 1'b0;
        state_next = state;

        if ((state == CMD) || (state == DATA)) begin
            tick = (divcnt == CW'(DIV - 1));
        end
        rise = tick && !ck;
        fall = tick && ck;

        cmd_end   = (state == CMD)  && fall && (bitcnt == 5'd31);
        byte_end  = (state == DATA) && fall && (bitcnt[2:0] == 3'd7);
        last_byte = byte_end && (bytecnt == BW'(N - 1));

        case (state)
            IDLE: state_next = CMD;
            CMD:  if (cmd_end)   state_next = DATA;
            DATA: if (last_byte) state_next = DONE;
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Registered SPI pins, shift registers, counters, and memory write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs      <= 1'b1;
            ck      <= 1'b0;
            mosi    <= 1'b0;
            w       <= 1'b0;
            a       <= '0;
            d       <= '0;
            done    <= 1'b0;
            divcnt  <= '0;
            bitcnt  <= '0;
            cmdsr   <= '0;
            rxsr    <= '0;
            bytecnt <= '0;
        end else begin
            w <= 1'b0;
            case (state)
                IDLE: begin
                    cs      <= 1'b0;
                    ck      <= 1'b0;
                    mosi    <= CMDWORD[31];
                    cmdsr   <= {CMDWORD[30:0], 1'b0};
                    divcnt  <= '0;
                    bitcnt  <= '0;
                    bytecnt <= '0;
                end

                CMD, DATA: begin
                    divcnt <= tick ? '0 : (divcnt + CW'(1));
                    if (tick) begin
                        ck <= ~ck;
                    end

                    if (rise && (state == DATA)) begin
                        rxsr <= {rxsr[6:0], miso};
                    end

                    if (fall) begin
                        bitcnt <= bitcnt + 5'd1;
                        if (state == CMD) begin
                            mosi  <= cmd_end ? 1'b0 : cmdsr[31];
                            cmdsr <= {cmdsr[30:0], 1'b0};
                        end else begin
                            mosi <= 1'b0;
                        end
                    end

                    if (byte_end) begin
                        d       <= rxsr;
                        a       <= bytecnt[AW-1:0];
                        w       <= 1'b1;
                        bytecnt <= bytecnt + BW'(1);
                    end

                    if (last_byte) begin
                        cs   <= 1'b1;
                        done <= 1'b1;
                    end
                end

                DONE: begin
                    cs   <= 1'b1;
                    ck   <= 1'b0;
                    mosi <= 1'b0;
                end

                default: begin
                    cs <= 1'b1;
                    ck <= 1'b0;
                end
            endcase
        end
    end

endmodule
